roce_stack_mm2s_engine: RTL and testbench
=========================================

Name: roce_stack_mm2s_engine

Overview:
- Read-side command executor for the RoCE stack data path: the reader that pairs with the request handlers' write of 104-bit MM2S commands.
- Accepts one MM2S command at a time in datamover command format and issues INCR AXI4 read bursts that never cross a 4 KB boundary.
- Forwards read data as an AXI4-Stream with correct tkeep/tlast to the RoCE read-data path.
- Returns one 8-bit status word per command.

Parameters:
- AXI4_DATA_WIDTH, 512, data bus width in bits; BYTES = AXI4_DATA_WIDTH/8.
- MAX_BURST_BEATS, 64, maximum beats per AR burst; MAX_BURST_BEATS*BYTES must be <= 4096.

Ports:
- axis_aclk_i  in  1  clock
- aresetn_i  in  1  asynchronous active-low reset
- s_cmd_valid_i  in  1  command valid
- s_cmd_ready_o  out  1  command ready
- s_cmd_data_i  in  104  command: [22:0] BTT, [23] TYPE, [30] EOF, [95:32] SADDR, [99:96] TAG; other bits ignored
- m_axi_araddr_o  out  64  burst address
- m_axi_arlen_o  out  8  beats-1
- m_axi_arsize_o  out  3  log2(BYTES)
- m_axi_arburst_o  out  2  constant 2'b01
- m_axi_arcache_o  out  4  constant 4'b0011
- m_axi_arprot_o  out  3  constant 0
- m_axi_arid_o  out  1  constant 0
- m_axi_arvalid_o  out  1  AR valid
- m_axi_arready_i  in  1  AR ready
- m_axi_rdata_i  in  AXI4_DATA_WIDTH  read data
- m_axi_rresp_i  in  2  read response
- m_axi_rlast_i  in  1  read last
- m_axi_rvalid_i  in  1  R valid
- m_axi_rready_o  out  1  R ready
- m_axis_tdata_o  out  AXI4_DATA_WIDTH  stream data
- m_axis_tkeep_o  out  BYTES  stream keep
- m_axis_tlast_o  out  1  stream last
- m_axis_tvalid_o  out  1  stream valid
- m_axis_tready_i  in  1  stream ready
- m_sts_data_o  out  8  status: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
- m_sts_valid_o  out  1  status valid
- m_sts_ready_i  in  1  status ready
- err_o  out  1  sticky error flag, set by any status with bit 7 = 0

Behaviour:
- Reset (async assert, sync release): state IDLE; every valid/ready output 0; all data/address outputs 0; err_o 0.
- IDLE:
  - s_cmd_ready_o = 1.
  - On handshake, latch SADDR, TAG, EOF, BTT.
  - Compute total_beats = ceil(BTT/BYTES) at 18 bits and last_keep = low (BTT mod BYTES, or BYTES if 0) bits set.
  - If BTT == 0, TYPE == 0, or SADDR[log2(BYTES)-1:0] != 0: go to STATUS with INTERR = 1 and issue no AXI traffic.
  - Otherwise go to ADDR.
- ADDR:
  - Burst beats = min(remaining_beats, MAX_BURST_BEATS, (4096 - addr[11:0])/BYTES).
  - arlen = beats - 1; arvalid held with stable address/len until arready, then go to DATA.
  - Registered outputs; arvalid rises the cycle after entering ADDR.
- DATA:
  - Pass-through: tvalid = rvalid, rready = tready, tdata = rdata, all combinational.
  - tkeep = all ones except on the final beat of the command, which uses last_keep.
  - tlast = EOF on the final beat of the command, else 0.
  - Each R handshake decrements remaining_beats.
  - RRESP 2'b10 sets SLVERR; 2'b11 sets DECERR. Both are accumulated over the whole command, and data is still forwarded.
  - On the rlast handshake: address += beats*BYTES; go to ADDR if remaining_beats > 0, else STATUS.
- Outside DATA: rready = 0 and tvalid = 0.
- Only one AR burst is outstanding at any time.
- STATUS:
  - sts_valid = 1 with {OKAY = no error bit set, SLVERR, DECERR, INTERR, TAG}.
  - Held stable until sts_ready, then return to IDLE (next command is accepted one cycle later).
- err_o: set on any status with OKAY = 0; cleared only by reset.
- Unexpected input: rlast arriving early or late relative to the computed beats sets INTERR; the burst ends at rlast.
- Reset asserted mid-burst: all state is dropped immediately and outputs return to reset values. No recovery of in-flight AXI beats is required.

Test Plan:
- Single command, BTT = 256, SADDR = 0x1000, EOF = 1, TAG = 5, OKAY responses -> one AR (addr 0x1000, arlen 3, arsize 6); 4 stream beats, all tkeep = all ones, tlast on beat 4; status 0x85.
- BTT = 100, SADDR = 0x0FC0, EOF = 1 -> first AR (0x0FC0, arlen 0), second AR (0x1000, arlen 0); beat 2 tkeep = 0x0000_000F_FFFF_FFFF (36 bytes) with tlast; status OKAY.
- BTT = 8192, SADDR = 0 -> two ARs (0x0, 0x1000), each arlen 63; 128 beats; tready toggled randomly with no beat lost or duplicated; status OKAY.
- Command with SADDR = 0x1004 -> no arvalid; status 0x10 | TAG; err_o = 1.
- RRESP = 2'b10 on beat 2 of 4 -> all 4 beats forwarded; status has bit 6 = 1, bit 7 = 0.
- Reset pulsed during the DATA phase -> all valids deassert immediately; a fresh command after reset completes normally with status OKAY.

Source files
------------

// File: rtl/roce_stack_mm2s_engine.sv
// MM2S command executor: turns one datamover read command into 4 KB-safe AXI4 INCR read
// bursts, forwards the read data as AXI4-Stream and returns one status byte per command.
module roce_stack_mm2s_engine #(
  parameter int unsigned AXI4_DATA_WIDTH = 512,
  parameter int unsigned MAX_BURST_BEATS = 64
) (
  input  logic                         axis_aclk_i,
  input  logic                         aresetn_i,
  input  logic                         s_cmd_valid_i,
  output logic                         s_cmd_ready_o,
  input  logic [103:0]                 s_cmd_data_i,
  output logic [63:0]                  m_axi_araddr_o,
  output logic [7:0]                   m_axi_arlen_o,
  output logic [2:0]                   m_axi_arsize_o,
  output logic [1:0]                   m_axi_arburst_o,
  output logic [3:0]                   m_axi_arcache_o,
  output logic [2:0]                   m_axi_arprot_o,
  output logic                         m_axi_arid_o,
  output logic                         m_axi_arvalid_o,
  input  logic                         m_axi_arready_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   m_axi_rdata_i,
  input  logic [1:0]                   m_axi_rresp_i,
  input  logic                         m_axi_rlast_i,
  input  logic                         m_axi_rvalid_i,
  output logic                         m_axi_rready_o,
  output logic [AXI4_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [AXI4_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                         m_axis_tlast_o,
  output logic                         m_axis_tvalid_o,
  input  logic                         m_axis_tready_i,
  output logic [7:0]                   m_sts_data_o,
  output logic                         m_sts_valid_o,
  input  logic                         m_sts_ready_i,
  output logic                         err_o
);
  localparam int unsigned BYTES = AXI4_DATA_WIDTH / 8;
  localparam int unsigned LOG2  = $clog2(BYTES);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StStatus} state_e;

  state_e             r_state, w_state_next;
  logic               r_init, r_err, r_eof, r_interr, r_slverr, r_decerr, r_arvalid;
  logic [63:0]        r_addr, r_araddr;
  logic [3:0]         r_tag;
  logic [17:0]        r_rem;
  logic [8:0]         r_bcnt;
  logic [7:0]         r_arlen;
  logic [BYTES-1:0]   r_last_keep;

  logic [23:0]        w_btt_round;
  logic [17:0]        w_total_beats, w_page_beats, w_beats;
  logic [12:0]        w_page_bytes;
  logic [LOG2-1:0]    w_btt_mod;
  logic [BYTES-1:0]   w_last_keep;
  logic               w_cmd_bad, w_r_hs, w_okay, w_final;
  logic               w_unused_cmd;

  assign w_btt_round   = 24'(s_cmd_data_i[22:0]) + 24'(BYTES - 1);
  assign w_total_beats = 18'(w_btt_round >> LOG2);
  assign w_btt_mod     = s_cmd_data_i[LOG2-1:0];
  assign w_cmd_bad     = (s_cmd_data_i[22:0] == 23'd0) || !s_cmd_data_i[23] ||
                         (s_cmd_data_i[32+LOG2-1:32] != '0);
  assign w_unused_cmd  = ^{s_cmd_data_i[103:100], s_cmd_data_i[31], s_cmd_data_i[29:24]};

  always_comb begin
    w_last_keep = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_last_keep[i] = (w_btt_mod == '0) || (LOG2'(i) < w_btt_mod);
    end
  end

  // Beats left before the next 4 KB page boundary.
  assign w_page_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_page_beats = 18'(w_page_bytes >> LOG2);

  always_comb begin
    w_beats = r_rem;
    if (w_beats > 18'(MAX_BURST_BEATS)) w_beats = 18'(MAX_BURST_BEATS);
    if (w_beats > w_page_beats)         w_beats = w_page_beats;
  end

  assign w_r_hs  = (r_state == StData) && m_axi_rvalid_i && m_axis_tready_i;
  assign w_okay  = !(r_interr || r_slverr || r_decerr);
  assign w_final = (r_rem == 18'd1);

  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (s_cmd_valid_i && r_init) w_state_next = w_cmd_bad ? StStatus : StAddr;
      StAddr:   if (r_arvalid && m_axi_arready_i) w_state_next = StData;
      StData:   if (w_r_hs && m_axi_rlast_i) w_state_next = (r_rem > 18'd1) ? StAddr : StStatus;
      StStatus: if (m_sts_ready_i) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_init      <= 1'b0;
      r_err       <= 1'b0;
      r_eof       <= 1'b0;
      r_interr    <= 1'b0;
      r_slverr    <= 1'b0;
      r_decerr    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_addr      <= '0;
      r_araddr    <= '0;
      r_tag       <= '0;
      r_rem       <= '0;
      r_bcnt      <= '0;
      r_arlen     <= '0;
      r_last_keep <= '0;
    end else begin
      r_init <= 1'b1;
      if (r_state == StStatus && !w_okay) r_err <= 1'b1;
      unique case (r_state)
        StIdle: if (s_cmd_valid_i && r_init) begin
          r_addr      <= s_cmd_data_i[95:32];
          r_tag       <= s_cmd_data_i[99:96];
          r_eof       <= s_cmd_data_i[30];
          r_rem       <= w_total_beats;
          r_last_keep <= w_last_keep;
          r_interr    <= w_cmd_bad;
          r_slverr    <= 1'b0;
          r_decerr    <= 1'b0;
        end
        StAddr: begin
          if (!r_arvalid) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_beats - 18'd1);
          end else if (m_axi_arready_i) begin
            r_arvalid <= 1'b0;
            r_bcnt    <= 9'(r_arlen) + 9'd1;
          end
        end
        StData: if (w_r_hs) begin
          if (r_rem != '0)  r_rem  <= r_rem - 18'd1;
          if (r_bcnt != '0) r_bcnt <= r_bcnt - 9'd1;
          if (m_axi_rresp_i == 2'b10) r_slverr <= 1'b1;
          if (m_axi_rresp_i == 2'b11) r_decerr <= 1'b1;
          // rlast must coincide with the last beat we asked for.
          if (m_axi_rlast_i != (r_bcnt == 9'd1)) r_interr <= 1'b1;
          if (m_axi_rlast_i) r_addr <= r_addr + ((64'(r_arlen) + 64'd1) << LOG2);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_cmd_ready_o   = (r_state == StIdle) && r_init;
    m_axi_araddr_o  = r_araddr;
    m_axi_arlen_o   = r_arlen;
    m_axi_arsize_o  = 3'(LOG2);
    m_axi_arburst_o = 2'b01;
    m_axi_arcache_o = 4'b0011;
    m_axi_arprot_o  = 3'b000;
    m_axi_arid_o    = 1'b0;
    m_axi_arvalid_o = r_arvalid;
    m_axi_rready_o  = (r_state == StData) && m_axis_tready_i;
    m_axis_tvalid_o = (r_state == StData) && m_axi_rvalid_i;
    m_axis_tdata_o  = (r_state == StData) ? m_axi_rdata_i : '0;
    m_axis_tkeep_o  = '0;
    if (r_state == StData) m_axis_tkeep_o = w_final ? r_last_keep : '1;
    m_axis_tlast_o  = (r_state == StData) && w_final && r_eof;
    m_sts_valid_o   = (r_state == StStatus);
    m_sts_data_o    = (r_state == StStatus) ? {w_okay, r_slverr, r_decerr, r_interr, r_tag} : '0;
    err_o           = r_err;
  end
endmodule

// File: tb/tb_roce_stack_mm2s_engine.sv
// Directed bench for roce_stack_mm2s_engine: command table plus an AXI read slave model
// with random handshakes and a stream checker.
module tb_roce_stack_mm2s_engine;
  localparam int DW = 512;
  localparam int NB = DW / 8;

  logic           clk = 1'b0;
  logic           aresetn;
  logic           s_cmd_valid, s_cmd_ready;
  logic [103:0]   s_cmd_data;
  logic [63:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize, arprot;
  logic [1:0]     arburst, rresp;
  logic [3:0]     arcache;
  logic           arid, arvalid, arready;
  logic [DW-1:0]  rdata, tdata;
  logic           rlast, rvalid, rready;
  logic [NB-1:0]  tkeep;
  logic           tlast, tvalid, tready;
  logic [7:0]     sts_data;
  logic           sts_valid, sts_ready, err;

  always #5 clk = ~clk;

  roce_stack_mm2s_engine #(.AXI4_DATA_WIDTH(DW), .MAX_BURST_BEATS(64)) dut (
    .axis_aclk_i(clk), .aresetn_i(aresetn),
    .s_cmd_valid_i(s_cmd_valid), .s_cmd_ready_o(s_cmd_ready), .s_cmd_data_i(s_cmd_data),
    .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
    .m_axi_arburst_o(arburst), .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot),
    .m_axi_arid_o(arid), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tlast_o(tlast),
    .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .m_sts_data_o(sts_data), .m_sts_valid_o(sts_valid), .m_sts_ready_i(sts_ready),
    .err_o(err)
  );

  typedef struct {
    logic [22:0] btt;   logic [63:0] saddr; logic eof; logic [3:0] tag; logic typ;
    int err_beat;       logic [1:0] err_resp;
    int n_ar;           logic [63:0] a0; logic [7:0] l0; logic [63:0] a1; logic [7:0] l1;
    int beats;          logic [63:0] keep; logic [7:0] sts; logic err;
  } vec_t;

  localparam logic [63:0] ONES = {64{1'b1}};

  vec_t        vecs[10];
  int          n_tests = 0, n_fail = 0;
  int          ar_n, cur_beats, err_beat;
  logic [63:0] ar_addr_log[4];
  logic [7:0]  ar_len_log[4];
  logic [63:0] cur_keep;
  logic        cur_eof;
  logic [31:0] beat_n, gbeat;
  logic [8:0]  r_left;
  logic        r_active, ar_hs, r_hs;
  logic [1:0]  cur_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI read slave and stream monitor: sample at negedge, drive 1 ns after posedge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00; tready = 1'b0;
    r_active = 1'b0; r_left = '0; gbeat = '0; ar_hs = 1'b0; r_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        r_active = 1'b0; r_left = '0; ar_hs = 1'b0; r_hs = 1'b0;
      end else begin
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (tvalid && tready) begin
          check("tdata", 64'(tdata == {16{beat_n}}), 64'd1);
          check("tkeep", 64'(tkeep), (beat_n == 32'(cur_beats - 1)) ? cur_keep : ONES);
          check("tlast", 64'(tlast), 64'(cur_eof && (beat_n == 32'(cur_beats - 1))));
          beat_n++;
        end
        if (r_hs) begin
          r_left--; gbeat++;
          if (r_left == '0) r_active = 1'b0;
        end
        if (ar_hs) begin
          check("ar_outstanding", 64'(r_active), 64'd0);
          check("arsize", 64'(arsize), 64'd6);
          check("arburst", 64'(arburst), 64'd1);
          if (ar_n < 4) begin
            ar_addr_log[ar_n] = araddr;
            ar_len_log[ar_n] = arlen;
          end
          ar_n++;
          r_active = 1'b1;
          r_left = 9'(arlen) + 9'd1;
        end
      end
      @(posedge clk); #1;
      arready = ($urandom_range(0, 1) == 1);
      tready  = ($urandom_range(0, 3) != 0);
      if (!r_active) rvalid = 1'b0;
      else if (!rvalid || r_hs) rvalid = ($urandom_range(0, 3) != 0);
      rdata = {16{gbeat}};
      rlast = (r_left == 9'd1);
      rresp = (int'(gbeat) == err_beat) ? cur_resp : 2'b00;
    end
  end

  task automatic start_cmd(input vec_t v);
    logic [103:0] c;
    bit           ok;
    ar_n = 0; beat_n = '0; gbeat = '0;
    cur_beats = v.beats; cur_keep = v.keep; cur_eof = v.eof;
    err_beat = v.err_beat; cur_resp = v.err_resp;
    c = '0;
    c[22:0] = v.btt; c[23] = v.typ; c[30] = v.eof; c[95:32] = v.saddr; c[99:96] = v.tag;
    c[29:24] = 6'h3F; c[103:100] = 4'hF;  // ignored bits
    @(posedge clk); #1;
    s_cmd_data = c; s_cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_cmd_ready;
    end
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    start_cmd(v);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = sts_valid;
    end
    check({tag, "_sts_seen"}, 64'(ok), 64'd1);
    check({tag, "_sts"}, 64'(sts_data), 64'(v.sts));
    repeat (2) @(negedge clk);
    check({tag, "_sts_hold"}, 64'({sts_valid, sts_data}), 64'({1'b1, v.sts}));
    @(posedge clk); #1 sts_ready = 1'b1;
    @(posedge clk); #1 sts_ready = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, 64'(err), 64'(v.err));
    check({tag, "_idle_ready"}, 64'(s_cmd_ready), 64'd1);
    check({tag, "_n_ar"}, 64'(ar_n), 64'(v.n_ar));
    check({tag, "_beats"}, 64'(beat_n), 64'(v.beats));
    if (v.n_ar >= 1 && ar_n >= 1) begin
      check({tag, "_ar0_addr"}, ar_addr_log[0], v.a0);
      check({tag, "_ar0_len"}, 64'(ar_len_log[0]), 64'(v.l0));
    end
    if (v.n_ar >= 2 && ar_n >= 2) begin
      check({tag, "_ar1_addr"}, ar_addr_log[1], v.a1);
      check({tag, "_ar1_len"}, 64'(ar_len_log[1]), 64'(v.l1));
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{23'd256, 64'h1000, 1'b1, 4'd5, 1'b1, -1, 2'b00,
                1, 64'h1000, 8'd3, 64'h0, 8'd0, 4, ONES, 8'h85, 1'b0};
    vecs[1] = '{23'd100, 64'h0FC0, 1'b1, 4'd1, 1'b1, -1, 2'b00,
                2, 64'h0FC0, 8'd0, 64'h1000, 8'd0, 2, 64'h0000_000F_FFFF_FFFF, 8'h81, 1'b0};
    vecs[2] = '{23'd8192, 64'h0, 1'b0, 4'd2, 1'b1, -1, 2'b00,
                2, 64'h0, 8'd63, 64'h1000, 8'd63, 128, ONES, 8'h82, 1'b0};
    vecs[3] = '{23'd4096, 64'h0F00, 1'b1, 4'd9, 1'b1, -1, 2'b00,
                2, 64'h0F00, 8'd3, 64'h1000, 8'd59, 64, ONES, 8'h89, 1'b0};
    vecs[4] = '{23'd1, 64'h40, 1'b1, 4'd10, 1'b1, -1, 2'b00,
                1, 64'h40, 8'd0, 64'h0, 8'd0, 1, 64'h1, 8'h8A, 1'b0};
    vecs[5] = '{23'd256, 64'h1004, 1'b1, 4'd3, 1'b1, -1, 2'b00,
                0, 64'h0, 8'd0, 64'h0, 8'd0, 0, ONES, 8'h13, 1'b1};
    vecs[6] = '{23'd256, 64'h2000, 1'b1, 4'd4, 1'b1, 1, 2'b10,
                1, 64'h2000, 8'd3, 64'h0, 8'd0, 4, ONES, 8'h44, 1'b1};
    vecs[7] = '{23'd64, 64'h3000, 1'b1, 4'd6, 1'b1, 0, 2'b11,
                1, 64'h3000, 8'd0, 64'h0, 8'd0, 1, ONES, 8'h26, 1'b1};
    vecs[8] = '{23'd64, 64'h4000, 1'b1, 4'd7, 1'b0, -1, 2'b00,
                0, 64'h0, 8'd0, 64'h0, 8'd0, 0, ONES, 8'h17, 1'b1};
    vecs[9] = '{23'd0, 64'h4000, 1'b1, 4'd8, 1'b1, -1, 2'b00,
                0, 64'h0, 8'd0, 64'h0, 8'd0, 0, ONES, 8'h18, 1'b1};

    aresetn = 1'b0; s_cmd_valid = 1'b0; s_cmd_data = '0; sts_ready = 1'b0;
    ar_n = 0; beat_n = '0; cur_beats = 0; cur_keep = ONES; cur_eof = 1'b0;
    err_beat = -1; cur_resp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 64'({s_cmd_ready, arvalid, rready, tvalid, sts_valid, err}), 64'd0);
    check("rst_araddr", araddr, 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_sts", 64'(sts_data), 64'd0);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_ready", 64'(s_cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a long transfer.
    start_cmd(vecs[2]);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (beat_n >= 32'd10);
    end
    check("midrst_progress", 64'(ok), 64'd1);
    @(posedge clk); #2 aresetn = 1'b0;
    #1;
    check("midrst_valids", 64'({s_cmd_ready, arvalid, rready, tvalid, sts_valid}), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_tkeep", 64'(tkeep), 64'd0);
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    run_vec(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
